// File: rtl/ack_sequencer.sv
// ack_sequencer
// Sequences the CPU interrupt-acknowledge handshake of an 8259-style interrupt
// controller. It tracks the INTA pulse train (two pulses in 8086 mode, three
// in MCS-80 mode) and the OCW3 poll read. It also emits single-cycle strobes
// that freeze the winning request into the ISR, mark the end of the acknowledge
// sequence, clear the ISR bit in auto-EOI mode and mark the end of a poll read.
// Every output comes from a flop.

module ack_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       interrupt_acknowledge_n,
    input  logic       u8086_or_mcs80_config,
    input  logic       auto_eoi_config,
    input  logic       poll_command,
    input  logic       read,
    output logic [2:0] control_state,
    output logic       latch_in_service,
    output logic       end_of_acknowledge_sequence,
    output logic       auto_eoi_clear,
    output logic       end_of_poll
);

    // ------------------------------------------------------------------
    // State encoding (visible directly on control_state)
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_READY = 3'b000;
    localparam logic [2:0] ST_ACK1  = 3'b001;
    localparam logic [2:0] ST_ACK2  = 3'b010;
    localparam logic [2:0] ST_ACK3  = 3'b011;
    localparam logic [2:0] ST_POLL  = 3'b100;

    // True when moving from a final acknowledge state back to READY.
    function automatic logic is_ack_complete(input logic [2:0] cur_state,
                                             input logic [2:0] nxt_state);
        logic result;
        result = ((cur_state == ST_ACK2) || (cur_state == ST_ACK3)) &&
                 (nxt_state == ST_READY);
        return result;
    endfunction

    // True when the encoding is one of the five defined states.
    function automatic logic is_legal_state(input logic [2:0] cur_state);
        logic result;
        case (cur_state)
            ST_READY, ST_ACK1, ST_ACK2, ST_ACK3, ST_POLL: result = 1'b1;
            default:                                       result = 1'b0;
        endcase
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic       inta_prev_r;
    logic       read_prev_r;
    logic       inta_armed_r;
    logic [2:0] state_r;
    logic       latch_in_service_r;
    logic       end_of_ack_r;
    logic       auto_eoi_clear_r;
    logic       end_of_poll_r;

    logic       inta_fall_s;
    logic       inta_rise_s;
    logic       read_fall_s;
    logic [2:0] next_state_s;
    logic       latch_next_s;
    logic       end_of_ack_next_s;
    logic       auto_eoi_next_s;
    logic       end_of_poll_next_s;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // The armed flag blocks a false INTA fall after reset when INTA is
    // already low: a fall only counts once INTA has been seen high.

    // History flops for INTA / read edge detection plus the INTA arm flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inta_prev_r  <= 1'b1;
            read_prev_r  <= 1'b0;
            inta_armed_r <= 1'b0;
        end else begin
            inta_prev_r  <= interrupt_acknowledge_n;
            read_prev_r  <= read;
            if (interrupt_acknowledge_n) begin
                inta_armed_r <= 1'b1;
            end else begin
                inta_armed_r <= inta_armed_r;
            end
        end
    end

    // Combinational edge strobes acted on at the current clock edge.
    always_comb begin
        inta_fall_s = inta_armed_r & inta_prev_r & ~interrupt_acknowledge_n;
        inta_rise_s = ~inta_prev_r & interrupt_acknowledge_n;
        read_fall_s = read_prev_r & ~read;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Holds the acknowledge/poll sequencing state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_READY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Chooses the next state from the detected INTA/read edges and poll request.
    always_comb begin
        next_state_s = ST_READY;
        case (state_r)
            ST_READY: begin
                // An INTA fall beats a poll request in the same cycle.
                if (inta_fall_s) begin
                    next_state_s = ST_ACK1;
                end else if (poll_command) begin
                    next_state_s = ST_POLL;
                end else begin
                    next_state_s = ST_READY;
                end
            end
            ST_ACK1: begin
                if (inta_rise_s) begin
                    next_state_s = ST_ACK2;
                end else begin
                    next_state_s = ST_ACK1;
                end
            end
            ST_ACK2: begin
                // The mode is only looked at on the rise that leaves ACK2.
                if (inta_rise_s) begin
                    if (u8086_or_mcs80_config) begin
                        next_state_s = ST_READY;
                    end else begin
                        next_state_s = ST_ACK3;
                    end
                end else begin
                    next_state_s = ST_ACK2;
                end
            end
            ST_ACK3: begin
                if (inta_rise_s) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_ACK3;
                end
            end
            ST_POLL: begin
                // A new acknowledge aborts the poll and wins over its read end.
                if (inta_fall_s) begin
                    next_state_s = ST_ACK1;
                end else if (read_fall_s) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_POLL;
                end
            end
            default: begin
                next_state_s = ST_READY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    // Derives the next-cycle strobe values from the transition being taken.
    always_comb begin
        latch_next_s       = 1'b0;
        end_of_ack_next_s  = 1'b0;
        auto_eoi_next_s    = 1'b0;
        end_of_poll_next_s = 1'b0;
        if (is_legal_state(state_r)) begin
            latch_next_s       = (next_state_s == ST_ACK1) && (state_r != ST_ACK1);
            end_of_ack_next_s  = is_ack_complete(state_r, next_state_s);
            auto_eoi_next_s    = end_of_ack_next_s & auto_eoi_config;
            end_of_poll_next_s = (state_r == ST_POLL) && (next_state_s == ST_READY);
        end else begin
            latch_next_s       = 1'b0;
            end_of_ack_next_s  = 1'b0;
            auto_eoi_next_s    = 1'b0;
            end_of_poll_next_s = 1'b0;
        end
    end

    // Registers the single-cycle strobes so they appear with the new state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_in_service_r <= 1'b0;
            end_of_ack_r       <= 1'b0;
            auto_eoi_clear_r   <= 1'b0;
            end_of_poll_r      <= 1'b0;
        end else begin
            latch_in_service_r <= latch_next_s;
            end_of_ack_r       <= end_of_ack_next_s;
            auto_eoi_clear_r   <= auto_eoi_next_s;
            end_of_poll_r      <= end_of_poll_next_s;
        end
    end

    assign control_state               = state_r;
    assign latch_in_service            = latch_in_service_r;
    assign end_of_acknowledge_sequence = end_of_ack_r;
    assign auto_eoi_clear              = auto_eoi_clear_r;
    assign end_of_poll                 = end_of_poll_r;

endmodule

// File: tb/tb_ack_sequencer.sv
// Scoreboard bench for ack_sequencer. Stimulus pushes the expected
// observation {state, latch, eoa, aeoi_clr, eop} before it drives the input
// change that causes it. The monitor samples on the falling clock edge. When
// the state changes or any strobe is high, it pops and compares one entry.
// Unexpected activity is reported as a FAIL.

module tb_ack_sequencer;

    logic       clock;
    logic       reset_n;
    logic       interrupt_acknowledge_n;
    logic       u8086_or_mcs80_config;
    logic       auto_eoi_config;
    logic       poll_command;
    logic       read;
    logic [2:0] control_state;
    logic       latch_in_service;
    logic       end_of_acknowledge_sequence;
    logic       auto_eoi_clear;
    logic       end_of_poll;

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] exp_q[$];
    string      name_q[$];

    ack_sequencer dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .interrupt_acknowledge_n     (interrupt_acknowledge_n),
        .u8086_or_mcs80_config       (u8086_or_mcs80_config),
        .auto_eoi_config             (auto_eoi_config),
        .poll_command                (poll_command),
        .read                        (read),
        .control_state               (control_state),
        .latch_in_service            (latch_in_service),
        .end_of_acknowledge_sequence (end_of_acknowledge_sequence),
        .auto_eoi_clear              (auto_eoi_clear),
        .end_of_poll                 (end_of_poll)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [2:0] st, input logic li, input logic eoa,
                             input logic aeoi, input logic eop, input string nm);
        exp_q.push_back({st, li, eoa, aeoi, eop});
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: compares observed activity against the scoreboard queue.
    initial begin
        logic [2:0] prev_state;
        logic [6:0] obs;
        logic [6:0] exp_v;
        string      nm;
        prev_state = 3'b000;
        forever begin
            @(negedge clock);
            obs = {control_state, latch_in_service, end_of_acknowledge_sequence,
                   auto_eoi_clear, end_of_poll};
            if ((obs[6:4] !== prev_state) || (obs[3:0] !== 4'b0000)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {25'd0, obs}, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    nm    = name_q.pop_front();
                    chk(nm, {25'd0, obs}, {25'd0, exp_v});
                end
            end
            prev_state = obs[6:4];
        end
    end

    // Full acknowledge sequence starting in READY with INTA high.
    task automatic ack_seq(input logic mode, input logic aeoi, input string tag);
        u8086_or_mcs80_config = mode;
        auto_eoi_config       = aeoi;
        expect_ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_ack1"});
        interrupt_acknowledge_n = 1'b0;
        step(2);
        expect_ev(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_ack2"});
        interrupt_acknowledge_n = 1'b1;
        step(2);
        interrupt_acknowledge_n = 1'b0;
        step(2);
        if (!mode) begin
            expect_ev(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_ack3"});
            interrupt_acknowledge_n = 1'b1;
            step(2);
            interrupt_acknowledge_n = 1'b0;
            step(2);
        end
        expect_ev(3'b000, 1'b0, 1'b1, aeoi, 1'b0, {tag, "_eoa"});
        interrupt_acknowledge_n = 1'b1;
        step(3);
    endtask

    // Directed stimulus.
    initial begin
        reset_n                 = 1'b0;
        interrupt_acknowledge_n = 1'b1;
        u8086_or_mcs80_config   = 1'b1;
        auto_eoi_config         = 1'b0;
        poll_command            = 1'b0;
        read                    = 1'b0;
        #1;
        chk("reset_state", {29'd0, control_state}, 32'd0);
        chk("reset_pulses", {28'd0, latch_in_service, end_of_acknowledge_sequence,
                             auto_eoi_clear, end_of_poll}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(2);

        // 8086 mode, no auto-EOI.
        ack_seq(1'b1, 1'b0, "m8086");

        // MCS-80 mode, auto-EOI.
        ack_seq(1'b0, 1'b1, "mcs80");

        // Poll read: read high three cycles, then low.
        expect_ev(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, "poll_enter");
        poll_command = 1'b1;
        read         = 1'b1;
        step(1);
        poll_command = 1'b0;
        step(2);
        expect_ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, "poll_end");
        read = 1'b0;
        step(3);

        // Poll and INTA fall together: acknowledge wins.
        u8086_or_mcs80_config = 1'b1;
        auto_eoi_config       = 1'b0;
        expect_ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "race_ack1");
        poll_command            = 1'b1;
        interrupt_acknowledge_n = 1'b0;
        step(1);
        poll_command = 1'b0;
        step(1);
        expect_ev(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "race_ack2");
        interrupt_acknowledge_n = 1'b1;
        step(2);
        interrupt_acknowledge_n = 1'b0;
        step(2);
        expect_ev(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "race_eoa");
        interrupt_acknowledge_n = 1'b1;
        step(3);

        // Reset while in ACK2, then a clean 8086 sequence.
        expect_ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "rst_ack1");
        interrupt_acknowledge_n = 1'b0;
        step(2);
        expect_ev(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "rst_ack2");
        interrupt_acknowledge_n = 1'b1;
        step(2);
        expect_ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "rst_abort");
        reset_n = 1'b0;
        #1;
        chk("rst_async_state", {29'd0, control_state}, 32'd0);
        chk("rst_async_pulses", {28'd0, latch_in_service, end_of_acknowledge_sequence,
                                 auto_eoi_clear, end_of_poll}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1);
        ack_seq(1'b1, 1'b0, "post_rst");

        // Poll request during ACK1 is ignored.
        expect_ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "ign_ack1");
        interrupt_acknowledge_n = 1'b0;
        step(1);
        poll_command = 1'b1;
        step(1);
        poll_command = 1'b0;
        step(1);
        expect_ev(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "ign_ack2");
        interrupt_acknowledge_n = 1'b1;
        step(2);
        interrupt_acknowledge_n = 1'b0;
        step(2);
        expect_ev(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "ign_eoa");
        interrupt_acknowledge_n = 1'b1;
        step(3);

        // Poll aborted by INTA fall arriving with the read end.
        expect_ev(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, "abort_poll");
        poll_command = 1'b1;
        read         = 1'b1;
        step(1);
        poll_command = 1'b0;
        step(2);
        expect_ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "abort_ack1");
        interrupt_acknowledge_n = 1'b0;
        read                    = 1'b0;
        step(2);
        expect_ev(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "abort_ack2");
        interrupt_acknowledge_n = 1'b1;
        step(2);
        interrupt_acknowledge_n = 1'b0;
        step(2);
        expect_ev(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, "abort_eoa");
        interrupt_acknowledge_n = 1'b1;
        step(3);

        // Reset released with INTA already low: no acknowledge until it cycles.
        reset_n = 1'b0;
        interrupt_acknowledge_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(4);
        chk("low_inta_hold", {29'd0, control_state}, 32'd0);
        interrupt_acknowledge_n = 1'b1;
        step(2);
        ack_seq(1'b1, 1'b0, "rearm");

        step(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ack_sequencer.md
ACK_SEQUENCER -- requirements
Module: ack_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: interrupt_acknowledge_n  in  1  CPU INTA strobe, active-low, sampled on clock.
REQ-004 SHALL have ports: u8086_or_mcs80_config  in  1  1 = 8086 mode (2 INTA pulses), 0 = MCS-80 mode (3 INTA pulses).
REQ-005 SHALL have ports: auto_eoi_config  in  1  1 = automatic end-of-interrupt enabled.
REQ-006 SHALL have ports: poll_command  in  1  one-cycle pulse, OCW3 poll request.
REQ-007 SHALL have ports: read  in  1  level, high while the CPU read cycle is active.
REQ-008 SHALL have ports: control_state  out  3  READY=000, ACK1=001, ACK2=010, ACK3=011, POLL=100.
REQ-009 SHALL have ports: latch_in_service  out  1  one-cycle pulse, freeze winner into ISR.
REQ-010 SHALL have ports: end_of_acknowledge_sequence  out  1  one-cycle pulse, last INTA pulse finished.
REQ-011 SHALL have ports: auto_eoi_clear  out  1  one-cycle pulse, clear ISR bit (AEOI).
REQ-012 SHALL have ports: end_of_poll  out  1  one-cycle pulse, poll read finished.

Function
REQ-013 SHALL register interrupt_acknowledge_n into inta_prev (reset 1) and read into read_prev (reset 0) every clock.
REQ-014 SHALL define inta_fall = inta_prev & ~interrupt_acknowledge_n, inta_rise = ~inta_prev & interrupt_acknowledge_n, read_fall = read_prev & ~read; all three evaluated combinationally, acted on at the same edge.
REQ-015 SHALL update control_state at the clock edge where the triggering event is detected; the new state is visible in the following cycle (zero extra latency).
REQ-016 READY: inta_fall -> ACK1; else poll_command -> POLL; else stay. inta_fall wins over simultaneous poll_command (poll discarded).
REQ-017 ACK1: inta_rise -> ACK2; all other inputs ignored.
REQ-018 ACK2: inta_rise -> READY if u8086_or_mcs80_config=1, -> ACK3 if 0; mode sampled at that edge only.
REQ-019 ACK3: inta_rise -> READY.
REQ-020 POLL: read_fall -> READY; inta_fall -> ACK1 (poll aborted, no end_of_poll); inta_fall wins over simultaneous read_fall.
REQ-021 poll_command in any state other than READY SHALL be ignored.
REQ-022 Unused encodings 101-111 SHALL return to READY on the next clock edge with no pulse outputs.
REQ-023 latch_in_service SHALL be high exactly the one cycle after every transition into ACK1.
REQ-024 end_of_acknowledge_sequence SHALL be high exactly the one cycle after ACK2->READY or ACK3->READY.
REQ-025 auto_eoi_clear SHALL equal end_of_acknowledge_sequence AND auto_eoi_config sampled at the same edge.
REQ-026 end_of_poll SHALL be high exactly the one cycle after POLL->READY via read_fall.
REQ-027 All outputs SHALL be registered; no pulse may be longer than one cycle.
REQ-028 INTA held low or high indefinitely SHALL hold state; no timeout.

Reset
REQ-029 reset_n low SHALL immediately force control_state=READY, all pulse outputs 0, inta_prev=1, read_prev=0, independent of clock.
REQ-030 reset asserted mid-sequence (ACK1/ACK2/ACK3/POLL) SHALL abandon it with no end_of_acknowledge_sequence or end_of_poll pulse.
REQ-031 After reset release with INTA already low, no inta_fall SHALL be detected until INTA returns high and falls again.

Verification
REQ-032 8086 mode, auto_eoi=0, two INTA pulses -> states 000,001,010,000; latch_in_service 1 cycle after first fall; end_of_acknowledge_sequence 1 cycle after second rise; auto_eoi_clear stays 0.
REQ-033 MCS-80 mode, auto_eoi=1, three INTA pulses -> states 000,001,010,011,000; end_of_acknowledge_sequence and auto_eoi_clear both pulse once after third rise.
REQ-034 poll_command pulse, read high 3 cycles then low -> state 100 then 000; end_of_poll pulses once; latch_in_service stays 0.
REQ-035 poll_command and INTA fall in same cycle from READY -> state 001, latch_in_service pulse, POLL never entered.
REQ-036 reset_n pulsed low while in ACK2 -> control_state 000 immediately, no pulses; subsequent full 8086 sequence behaves as REQ-032.
REQ-037 poll_command during ACK1 -> ignored; sequence completes normally, state returns to 000, no end_of_poll.
